trig_seq_ctrl: RTL and testbench

// - Initiator side of the time-control trigger interface: drives trigger into a time-base counter and consumes its sync/en/t_out stream.
// - Issues REPS back-to-back runs, detects end of each run, drops trigger to re-arm, inserts an IDLE gap, reports done/errors.
// - Sits between the register/tProc side and the signal generator time base.

---
 rtl/trig_seq_ctrl_if.sv | 13 +
 rtl/trig_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_trig_seq_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_seq_ctrl_if.sv
// Trigger/time-base link: the controller drives trigger and receives the
// time base's sync/enable/time-index stream.
interface trig_seq_ctrl_if #(
  parameter int B = 8
);
  logic         trigger;
  logic         sync_in;
  logic         en_in;
  logic [B-1:0] t_in;

  modport master (output trigger, input sync_in, en_in, t_in);
  modport slave  (input trigger, output sync_in, en_in, t_in);
endinterface

// File: rtl/trig_seq_ctrl.sv
// Trigger sequencer: issues REPS runs into a time base with re-arm and idle gaps.
// Optional t_in stream checker built when TRIG_SEQ_CHECK_EN is defined.
module trig_seq_ctrl #(
  parameter int B  = 8,
  parameter int NR = 16,
  parameter int NW = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   stop,
  trig_seq_ctrl_if.master        tbase,
  input  logic [NR-1:0]          REPS_REG,
  input  logic [NW-1:0]          IDLE_REG,
  input  logic [NW-1:0]          TOUT_REG,
  output logic                   busy,
  output logic                   done,
  output logic [NR-1:0]          rep_cnt,
  output logic                   tout_err,
  output logic                   seq_err
);

  typedef enum logic [2:0] {
    IDLE_ST, TRIG_ST, RUN_ST, REL_ST, GAP_ST, ABORT_ST, DONE_ST
  } state_t;

  state_t        state;
  logic [NR-1:0] reps_q;
  logic [NW-1:0] idle_q;
  logic [NW-1:0] tout_q;
  logic [NW-1:0] wait_cnt;
  logic [NW-1:0] gap_cnt;
  logic          en_d;
  logic          trigger_q;
  logic          start_ok;
  logic [NR-1:0] rep_inc;

  assign start_ok = (state == IDLE_ST) && start && !stop;
  assign rep_inc  = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;

  // NOTE: trigger comes straight from a flop so the time base never sees a
  // combinational glitch, and the async reset clears it immediately.
  assign tbase.trigger = trigger_q;

  // NOTE: all state here uses non-blocking assignments so every branch reads
  // the values from before this edge regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE_ST;
      reps_q    <= '0;
      idle_q    <= '0;
      tout_q    <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      en_d      <= 1'b0;
      trigger_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rep_cnt   <= '0;
      tout_err  <= 1'b0;
    end else begin
      en_d <= tbase.en_in;
      done <= 1'b0;
      // stop overrides everything once a sequence is in flight
      if (stop && state != IDLE_ST && state != DONE_ST) begin
        state     <= ABORT_ST;
        trigger_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE_ST: if (start_ok) begin
            reps_q   <= REPS_REG;
            idle_q   <= IDLE_REG;
            tout_q   <= TOUT_REG;
            rep_cnt  <= '0;
            tout_err <= 1'b0;
            busy     <= 1'b1;
            wait_cnt <= '0;
            if (REPS_REG == '0) begin
              state <= DONE_ST;
            end else begin
              state     <= TRIG_ST;
              trigger_q <= 1'b1;
            end
          end
          TRIG_ST: begin
            if (tbase.sync_in) begin
              state <= RUN_ST;
            end else if (tout_q != '0) begin
              if (wait_cnt + 1'b1 == tout_q) begin
                tout_err  <= 1'b1;
                trigger_q <= 1'b0;
                state     <= ABORT_ST;
              end else begin
                wait_cnt <= wait_cnt + 1'b1;
              end
            end
          end
          RUN_ST: if (en_d && !tbase.en_in) begin
            rep_cnt   <= rep_inc;
            trigger_q <= 1'b0;
            state     <= REL_ST;
          end
          REL_ST: begin
            if (rep_cnt == reps_q) begin
              state <= DONE_ST;
            end else if (idle_q == '0) begin
              state     <= TRIG_ST;
              trigger_q <= 1'b1;
              wait_cnt  <= '0;
            end else begin
              state   <= GAP_ST;
              gap_cnt <= '0;
            end
          end
          GAP_ST: begin
            if (gap_cnt == idle_q - 1'b1) begin
              state     <= TRIG_ST;
              trigger_q <= 1'b1;
              wait_cnt  <= '0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          ABORT_ST: if (!tbase.en_in) begin
            state <= IDLE_ST;
            busy  <= 1'b0;
          end
          DONE_ST: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE_ST;
          end
          default: state <= IDLE_ST;
        endcase
      end
    end
  end

`ifdef TRIG_SEQ_CHECK_EN
  localparam logic [B-1:0] CNT_MAX = {1'b0, {(B-1){1'b1}}};

  logic [B-1:0] t_prev;
  logic         t_seen;
  logic         seq_err_q;

  // The time index must start at 0, advance by at most one per cycle and
  // end on CNT_MAX when enable falls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t_prev    <= '0;
      t_seen    <= 1'b0;
      seq_err_q <= 1'b0;
    end else if (start_ok) begin
      t_seen    <= 1'b0;
      seq_err_q <= 1'b0;
    end else if (state == RUN_ST && !stop) begin
      if (tbase.en_in) begin
        t_seen <= 1'b1;
        t_prev <= tbase.t_in;
        if (!t_seen ? (tbase.t_in != '0)
                    : (tbase.t_in != t_prev && tbase.t_in != t_prev + 1'b1))
          seq_err_q <= 1'b1;
      end else if (en_d) begin
        t_seen <= 1'b0;
        if (t_prev != CNT_MAX) seq_err_q <= 1'b1;
      end
    end
  end

  assign seq_err = seq_err_q;
`else
  logic [B-1:0] unused_t_in;
  assign unused_t_in = tbase.t_in;
  assign seq_err     = 1'b0;
`endif

endmodule

// File: tb/tb_trig_seq_ctrl.sv
// Bench for trig_seq_ctrl: time-base model, run-level reference model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_trig_seq_ctrl;
  localparam int B = 8, NR = 16, NW = 16;
  localparam int CNT_MAX = 2**(B-1) - 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [NR-1:0] REPS_REG = '0;
  logic [NW-1:0] IDLE_REG = '0;
  logic [NW-1:0] TOUT_REG = '0;
  logic          busy, done, tout_err, seq_err;
  logic [NR-1:0] rep_cnt;

  trig_seq_ctrl_if #(.B(B)) tif ();

  trig_seq_ctrl #(.B(B), .NR(NR), .NW(NW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .tbase(tif),
    .REPS_REG(REPS_REG), .IDLE_REG(IDLE_REG), .TOUT_REG(TOUT_REG),
    .busy(busy), .done(done), .rep_cnt(rep_cnt),
    .tout_err(tout_err), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- time-base model ----------------
  int tb_st = 0, hold = 0, wait_reg = 0;
  bit no_sync = 0, skip = 0;

  initial begin
    tif.sync_in = 1'b0;
    tif.en_in   = 1'b0;
    tif.t_in    = '0;
  end

  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      tb_st = 0; hold = 0;
      tif.sync_in = 1'b0; tif.en_in = 1'b0; tif.t_in = '0;
    end else begin
      case (tb_st)
        0: begin
          tif.en_in = 1'b0;
          if (tif.trigger && !no_sync) begin tif.sync_in = 1'b1; tb_st = 1; end
        end
        1: begin
          tif.sync_in = 1'b0; tif.en_in = 1'b1; tif.t_in = '0; hold = 0; tb_st = 2;
        end
        2: if (hold == wait_reg) begin
          hold = 0;
          if (tif.t_in == CNT_MAX) begin tif.en_in = 1'b0; tif.t_in = '0; tb_st = 3; end
          else if (skip && tif.t_in == 40) tif.t_in = 8'd42;
          else tif.t_in = tif.t_in + 8'd1;
        end else hold++;
        3: if (!tif.trigger) tb_st = 0;
        default: tb_st = 0;
      endcase
    end
  end

  // ---------------- run-level reference model ----------------
  // Values computed at an edge are what the outputs must show for the
  // following cycle.
  typedef enum {P_IDLE, P_ARM, P_RUN, P_LOW, P_FIN, P_ABORT} phase_t;
  phase_t ph = P_IDLE;
  bit m_trig = 0, m_busy = 0, m_done = 0, m_tout = 0, m_seq = 0;
  bit m_en_prev = 0, m_seen = 0, m_fell = 0, m_bad = 0;
  int m_rep = 0, m_reps = 0, m_idle = 0, m_tout_lim = 0, m_wait = 0, m_low = 0, m_tlast = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph = P_IDLE; m_trig = 0; m_busy = 0; m_done = 0; m_tout = 0; m_seq = 0;
      m_rep = 0; m_en_prev = 0; m_seen = 0;
    end else begin
      m_done = 0;
      m_bad  = 0;
      m_fell = m_en_prev && !tif.en_in;
      if (stop && ph != P_IDLE && ph != P_FIN) begin
        ph = P_ABORT; m_trig = 0;
      end else begin
        case (ph)
          P_IDLE: if (start && !stop) begin
            m_reps = REPS_REG; m_idle = IDLE_REG; m_tout_lim = TOUT_REG;
            m_rep = 0; m_tout = 0; m_seq = 0; m_busy = 1; m_seen = 0;
            if (m_reps == 0) ph = P_FIN;
            else begin ph = P_ARM; m_trig = 1; m_wait = 0; end
          end
          P_ARM: begin
            if (tif.sync_in) begin ph = P_RUN; m_seen = 0; end
            else if (m_tout_lim != 0) begin
              m_wait++;
              if (m_wait == m_tout_lim) begin m_tout = 1; m_trig = 0; ph = P_ABORT; end
            end
          end
          P_RUN: begin
            if (tif.en_in) begin
              if (!m_seen) m_bad = (tif.t_in != 0);
              else m_bad = !(int'(tif.t_in) == m_tlast || int'(tif.t_in) == m_tlast + 1);
              m_seen = 1; m_tlast = tif.t_in;
            end else if (m_fell) begin
              m_bad = (m_tlast != CNT_MAX);
              m_seen = 0;
              m_rep++; m_trig = 0; ph = P_LOW;
              m_low = (m_rep == m_reps) ? 1 : 1 + m_idle;
            end
          end
          P_LOW: begin
            m_low--;
            if (m_low == 0) begin
              if (m_rep == m_reps) ph = P_FIN;
              else begin ph = P_ARM; m_trig = 1; m_wait = 0; end
            end
          end
          P_FIN: begin m_done = 1; m_busy = 0; ph = P_IDLE; end
          P_ABORT: if (!tif.en_in) begin m_busy = 0; ph = P_IDLE; end
          default: ph = P_IDLE;
        endcase
      end
`ifdef TRIG_SEQ_CHECK_EN
      if (m_bad) m_seq = 1;
`endif
      m_en_prev = tif.en_in;
    end
  end

  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_trigger",  tif.trigger, m_trig);
      check("cyc_busy",     busy,        m_busy);
      check("cyc_done",     done,        m_done);
      check("cyc_rep_cnt",  rep_cnt,     m_rep);
      check("cyc_tout_err", tout_err,    m_tout);
      check("cyc_seq_err",  seq_err,     m_seq);
    end
  end

  // ---------------- activity monitor ----------------
  int trig_rises = 0, done_cnt = 0, en_cycles = 0, n_gaps = 0, gap_sum = 0, last_gap = 0, low_len = 0;
  bit trig_prev = 0;
  always @(negedge clk) begin
    if (tif.en_in) en_cycles++;
    if (done) done_cnt++;
    if (tif.trigger && !trig_prev) begin
      trig_rises++;
      if (low_len > 0) begin n_gaps++; gap_sum += low_len; last_gap = low_len; end
    end
    if (busy && !tif.trigger) low_len++; else low_len = 0;
    trig_prev = tif.trigger;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int reps, input int idle, input int tout);
    REPS_REG = NR'(reps); IDLE_REG = NW'(idle); TOUT_REG = NW'(tout);
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    // scrambled registers must not affect a sequence already accepted
    REPS_REG = 16'd7; IDLE_REG = 16'd9; TOUT_REG = 16'd1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    check({name, "_idle_in_time"}, busy, 0);
    tick(); tick();
  endtask

  task automatic wait_run(input int rep, input int tval, input string name);
    int n = 0;
    while (!(rep_cnt == NR'(rep) && tif.en_in && tif.t_in == B'(tval)) && n < 2000) begin tick(); n++; end
    check({name, "_reached"}, n < 2000, 1);
  endtask

  int b_rise, b_done, b_en, b_gaps, b_gsum, k;

  task automatic snap();
    b_rise = trig_rises; b_done = done_cnt; b_en = en_cycles; b_gaps = n_gaps; b_gsum = gap_sum;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_trigger", tif.trigger, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rep_cnt", rep_cnt, 0);
    check("rst_tout_err", tout_err, 0);
    check("rst_seq_err", seq_err, 0);
    rstn = 1'b1;
    cmp_on = 1;
    tick();

    // three runs with a 4-cycle gap
    snap();
    do_start(3, 4, 0);
    check("r3_trig_rise", tif.trigger, 1);
    wait_idle(1000, "r3");
    check("r3_rises", trig_rises - b_rise, 3);
    check("r3_done", done_cnt - b_done, 1);
    check("r3_rep_cnt", rep_cnt, 3);
    check("r3_en_cycles", en_cycles - b_en, 384);
    check("r3_gaps", n_gaps - b_gaps, 2);
    check("r3_gap_sum", gap_sum - b_gsum, 10);
    check("r3_seq_err", seq_err, 0);

    // zero repetitions
    snap();
    do_start(0, 0, 0);
    check("r0_busy", busy, 1);
    check("r0_done_early", done, 0);
    tick();
    check("r0_done", done, 1);
    check("r0_busy_drop", busy, 0);
    tick();
    check("r0_done_pulse", done, 0);
    check("r0_rep_cnt", rep_cnt, 0);
    check("r0_no_trig", trig_rises - b_rise, 0);

    // sync never arrives
    snap();
    no_sync = 1;
    do_start(2, 0, 10);
    check("to_trig_rise", tif.trigger, 1);
    for (k = 1; k <= 40; k++) begin tick(); if (tout_err) break; end
    check("to_latency", k, 10);
    check("to_trig_low", tif.trigger, 0);
    tick();
    check("to_busy_low", busy, 0);
    check("to_no_done", done_cnt - b_done, 0);
    no_sync = 0;
    tick();

    // start together with stop is ignored
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_tout_kept", tout_err, 1);
    tick();
    check("ss_trigger", tif.trigger, 0);

    // abort during the second run
    snap();
    do_start(5, 2, 0);
    check("ab_tout_cleared", tout_err, 0);
    wait_run(1, 50, "ab_run2");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("ab_trig_low", tif.trigger, 0);
    check("ab_still_busy", busy, 1);
    wait_idle(300, "ab");
    check("ab_rep_cnt", rep_cnt, 1);
    check("ab_no_done", done_cnt - b_done, 0);
    check("ab_en_low", tif.en_in, 0);

    // slow time base, no idle gap
    snap();
    wait_reg = 3;
    do_start(2, 0, 3);
    wait_idle(1500, "slow");
    check("slow_done", done_cnt - b_done, 1);
    check("slow_rep_cnt", rep_cnt, 2);
    check("slow_en_cycles", en_cycles - b_en, 1024);
    check("slow_gap", last_gap, 1);
    check("slow_seq_err", seq_err, 0);
    check("slow_tout_err", tout_err, 0);
    wait_reg = 0;

    // time index skips a value
    snap();
    skip = 1;
    do_start(2, 1, 0);
    wait_idle(700, "skip");
    check("skip_done", done_cnt - b_done, 1);
    check("skip_rep_cnt", rep_cnt, 2);
    check("skip_en_cycles", en_cycles - b_en, 254);
`ifdef TRIG_SEQ_CHECK_EN
    check("skip_seq_err", seq_err, 1);
`else
    check("skip_seq_err", seq_err, 0);
`endif
    skip = 0;

    // asynchronous reset in the middle of the second run
    do_start(2, 0, 0);
    wait_run(1, 20, "rst_run2");
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check("arst_trigger", tif.trigger, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_rep_cnt", rep_cnt, 0);
    check("arst_tout_err", tout_err, 0);
    check("arst_seq_err", seq_err, 0);
    repeat (3) @(posedge clk);
    #3;
    rstn = 1'b1;
    tick();

    // recovery after reset
    snap();
    do_start(1, 0, 0);
    wait_idle(400, "rec");
    check("rec_done", done_cnt - b_done, 1);
    check("rec_rep_cnt", rep_cnt, 1);
    check("rec_rises", trig_rises - b_rise, 1);

    cmp_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
    $fatal(1);
  end

endmodule
